// File: rtl/uart_svc_pkg.sv
// uart_svc_pkg: state encodings and default terminator for the UART test services.
package uart_svc_pkg;
    typedef enum logic [2:0] {R_IDLE, R_LISTEN, R_PEND, R_WAIT, R_DONE} rep_state_t;
    typedef enum logic [2:0] {C_IDLE, C_GETN, C_SEND, C_WAIT, C_DONE} cnt_state_t;
    localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h00;
endpackage

// File: rtl/uart_test_services_tx_byte_sender.sv
// tx_byte_sender: one-byte transmit handshake shared by the replayer and counter FSMs.
module tx_byte_sender (
    input  logic i_pend,
    input  logic i_wait,
    input  logic i_tx_active,
    input  logic i_tx_done,
    output logic o_start,
    output logic o_finish
);
    // Start is combinational so a pending byte goes out in the very cycle the UART frees up.
    assign o_start  = i_pend & ~i_tx_active;
    assign o_finish = i_wait & i_tx_done;
endmodule

// File: rtl/uart_test_services.sv
// uart_test_services: fake ADC, byte replayer and counter-reply sharing one UART transmitter.
module uart_test_services
    import uart_svc_pkg::*;
#(
    parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adc_step,
    output logic [7:0] adc_data,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       rep_activate,
    input  logic       cnt_activate,
    output logic       rep_done,
    output logic       cnt_done
);
    rep_state_t r_rstate;
    cnt_state_t r_cstate;
    logic [7:0] r_adc, r_rbyte, r_n, r_idx, r_tx_last;
    logic       w_rstart, w_rfin, w_cstart, w_cfin, w_cnt_on;
    logic [7:0] w_idx_nxt;

    // The replayer owns tx whenever it is enabled, so the counter is held idle meanwhile.
    assign w_cnt_on  = cnt_activate & ~rep_activate;
    assign w_idx_nxt = r_idx + 8'd1;

    tx_byte_sender u_rep_tx (
        .i_pend(r_rstate == R_PEND), .i_wait(r_rstate == R_WAIT),
        .i_tx_active(tx_active), .i_tx_done(tx_done),
        .o_start(w_rstart), .o_finish(w_rfin)
    );

    tx_byte_sender u_cnt_tx (
        .i_pend(r_cstate == C_SEND), .i_wait(r_cstate == C_WAIT),
        .i_tx_active(tx_active), .i_tx_done(tx_done),
        .o_start(w_cstart), .o_finish(w_cfin)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rstate <= R_IDLE;
            r_rbyte  <= '0;
        end else if (!rep_activate) begin
            r_rstate <= R_IDLE;
            r_rbyte  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE:   r_rstate <= R_LISTEN;
                R_LISTEN: if (rx_ready) begin
                    r_rstate <= (rx_data == TERM_BYTE) ? R_DONE : R_PEND;
                    if (rx_data != TERM_BYTE) r_rbyte <= rx_data;
                end
                R_PEND:   if (w_rstart) r_rstate <= R_WAIT;
                R_WAIT:   if (w_rfin) r_rstate <= R_LISTEN;
                default:  r_rstate <= r_rstate;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cstate <= C_IDLE;
            r_n      <= '0;
            r_idx    <= '0;
        end else if (!w_cnt_on) begin
            r_cstate <= C_IDLE;
            r_n      <= '0;
            r_idx    <= '0;
        end else begin
            case (r_cstate)
                C_IDLE:  r_cstate <= C_GETN;
                C_GETN:  if (rx_ready) begin
                    r_n      <= rx_data;
                    r_idx    <= '0;
                    r_cstate <= (rx_data == 8'd0) ? C_DONE : C_SEND;
                end
                C_SEND:  if (w_cstart) r_cstate <= C_WAIT;
                C_WAIT:  if (w_cfin) begin
                    r_idx    <= w_idx_nxt;
                    r_cstate <= (w_idx_nxt == r_n) ? C_DONE : C_SEND;
                end
                default: r_cstate <= r_cstate;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adc     <= '0;
            r_tx_last <= '0;
        end else begin
            if (adc_step) r_adc <= r_adc + 8'd1;
            r_tx_last <= tx_data;
        end
    end

    assign adc_data = r_adc;
    assign tx_start = rep_activate ? w_rstart : (w_cnt_on & w_cstart);
    assign tx_data  = rep_activate ? r_rbyte : cnt_activate ? r_idx : r_tx_last;
    assign rep_done = (r_rstate == R_DONE);
    assign cnt_done = (r_cstate == C_DONE);
endmodule

// File: tb/tb_uart_test_services.sv
// tb_uart_test_services: bench with an emulated UART transmitter and byte-stream reference model.
module tb_uart_test_services;
    logic       clk = 1'b0;
    logic       reset, adc_step, rx_ready, tx_active, tx_done, rep_activate, cnt_activate;
    logic [7:0] rx_data, adc_data, tx_data;
    logic       tx_start, rep_done, cnt_done;
    int         n_tests = 0, n_fail = 0, cycle = 0, uart_len = 3, uart_cnt = 0;
    bit         force_busy = 0, consec_err = 0, overlap_err = 0, prev_start = 0;
    logic [7:0] sent[$];
    int         sent_cyc[$];

    typedef struct {int steps; logic [7:0] exp;} adc_vec_t;
    typedef struct {int n; int len;} cnt_vec_t;

    uart_test_services #(.TERM_BYTE(8'h00)) dut (
        .clk(clk), .reset(reset), .adc_step(adc_step), .adc_data(adc_data),
        .rx_ready(rx_ready), .rx_data(rx_data), .tx_active(tx_active), .tx_done(tx_done),
        .tx_data(tx_data), .tx_start(tx_start), .rep_activate(rep_activate),
        .cnt_activate(cnt_activate), .rep_done(rep_done), .cnt_done(cnt_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // UART emulator: records every started byte, stays busy uart_len cycles, then pulses tx_done.
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                sent.push_back(tx_data);
                sent_cyc.push_back(cycle);
                if (prev_start) consec_err = 1;
                if (uart_cnt > 0) overlap_err = 1;
                uart_cnt = uart_len;
            end
            prev_start = (tx_start === 1'b1);
            @(posedge clk);
            #2;
            tx_done = 1'b0;
            if (uart_cnt > 0) begin
                uart_cnt--;
                tx_done = (uart_cnt == 0);
            end
            tx_active = force_busy || (uart_cnt > 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic check_seq(input string nm, input logic [7:0] exp[$]);
        int bad = 0;
        check({nm, "_count"}, sent.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sent.size(); i++)
            if (sent[i] != exp[i]) bad++;
        check({nm, "_bytes_wrong"}, bad, 0);
        sent.delete();
        sent_cyc.delete();
    endtask

    task automatic run_rep(input logic [7:0] bytes[$], input int len);
        int rxc[$];
        int lat_bad = 0;
        uart_len     = len;
        rep_activate = 1'b1;
        tick(2);
        foreach (bytes[i]) begin
            rxc.push_back(cycle);
            send_rx(bytes[i]);
            tick(len + 4);
        end
        send_rx(8'h00);
        tick(3);
        check("rep_done", rep_done, 1);
        for (int i = 0; i < rxc.size() && i < sent_cyc.size(); i++)
            if (sent_cyc[i] - rxc[i] != 1) lat_bad++;
        check("rep_latency_bad", lat_bad, 0);
        check_seq("rep_echo", bytes);
        rep_activate = 1'b0;
        tick(1);
        check("rep_done_clear", rep_done, 0);
    endtask

    task automatic run_cnt(input int n, input int len);
        logic [7:0] q[$];
        int k = 0;
        uart_len     = len;
        cnt_activate = 1'b1;
        tick(2);
        send_rx(8'(n));
        while (cnt_done !== 1'b1 && k < 3000) begin
            tick(1);
            k++;
        end
        tick(3);
        check("cnt_done", cnt_done, 1);
        for (int i = 0; i < n; i++) q.push_back(8'(i));
        check_seq("cnt_seq", q);
        cnt_activate = 1'b0;
        tick(1);
        check("cnt_done_clear", cnt_done, 0);
    endtask

    initial begin
        adc_vec_t   av[4];
        cnt_vec_t   cv[4];
        logic [7:0] q[$];
        int         fc, k;
        av = '{'{5, 8'd5}, '{256, 8'd5}, '{1, 8'd6}, '{250, 8'd0}};
        cv = '{'{3, 3}, '{1, 1}, '{0, 2}, '{5, 2}};
        reset = 1'b1; adc_step = 1'b0; rx_ready = 1'b0; rx_data = '0;
        rep_activate = 1'b0; cnt_activate = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_adc", adc_data, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_tx_start", tx_start, 0);
        check("reset_rep_done", rep_done, 0);
        check("reset_cnt_done", cnt_done, 0);
        tick(2);
        reset = 1'b1;

        foreach (av[i]) begin
            repeat (av[i].steps) begin
                adc_step = 1'b1;
                tick(1);
            end
            adc_step = 1'b0;
            tick(1);
            check($sformatf("adc_vec%0d", i), adc_data, av[i].exp);
        end

        q = '{8'h41, 8'h42};
        run_rep(q, 3);
        foreach (cv[i]) run_cnt(cv[i].n, cv[i].len);

        // Replayer stalled by a busy transmitter; a byte arriving while pending is dropped.
        uart_len = 3;
        rep_activate = 1'b1;
        tick(2);
        force_busy = 1'b1;
        tick(1);
        send_rx(8'h55);
        tick(3);
        send_rx(8'h66);
        tick(4);
        check("busy_no_tx", sent.size(), 0);
        force_busy = 1'b0;
        fc = cycle;
        tick(2);
        check("busy_start_count", sent.size(), 1);
        check("busy_start_cycle", (sent_cyc.size() > 0) ? sent_cyc[0] - fc : -1, 0);
        tick(10);
        q = '{8'h55};
        check_seq("busy_echo", q);
        send_rx(8'h00);
        tick(2);
        check("busy_rep_done", rep_done, 1);
        rep_activate = 1'b0;
        tick(2);

        // Counter abandoned after three bytes of eight.
        cnt_activate = 1'b1;
        tick(2);
        send_rx(8'd8);
        k = 0;
        while (sent.size() < 3 && k < 200) begin
            tick(1);
            k++;
        end
        cnt_activate = 1'b0;
        tick(1);
        check("drop_cnt_done", cnt_done, 0);
        tick(30);
        q = '{8'd0, 8'd1, 8'd2};
        check_seq("drop_seq", q);

        // Both enables: replayer owns tx, counter starts only once the replayer lets go.
        rep_activate = 1'b1;
        cnt_activate = 1'b1;
        tick(2);
        send_rx(8'h05);
        tick(8);
        q = '{8'h05};
        check_seq("both_echo", q);
        check("both_cnt_idle", cnt_done, 0);
        send_rx(8'h00);
        tick(2);
        check("both_rep_done", rep_done, 1);
        rep_activate = 1'b0;
        tick(2);
        send_rx(8'd2);
        tick(15);
        q = '{8'd0, 8'd1};
        check_seq("both_cnt_seq", q);
        check("both_cnt_done", cnt_done, 1);
        cnt_activate = 1'b0;
        tick(2);

        for (int r = 0; r < 4; r++) begin
            q.delete();
            repeat ($urandom_range(1, 5)) q.push_back(8'($urandom_range(1, 255)));
            run_rep(q, $urandom_range(1, 4));
            run_cnt($urandom_range(1, 40), $urandom_range(1, 4));
        end
        run_cnt(255, 1);

        // Asynchronous reset in the middle of a counter session.
        repeat (3) begin
            adc_step = 1'b1;
            tick(1);
        end
        adc_step = 1'b0;
        uart_len = 3;
        cnt_activate = 1'b1;
        tick(2);
        send_rx(8'd20);
        tick(7);
        check("async_mid_session", sent.size() > 0, 1);
        #2 reset = 1'b0;
        #1;
        check("async_adc", adc_data, 0);
        check("async_tx_data", tx_data, 0);
        check("async_tx_start", tx_start, 0);
        check("async_cnt_done", cnt_done, 0);
        check("async_rep_done", rep_done, 0);
        tick(1);
        reset = 1'b1;
        cnt_activate = 1'b0;
        adc_step = 1'b1;
        tick(1);
        adc_step = 1'b0;
        check("post_reset_first_edge_adc", adc_data, 1);
        sent.delete();
        tick(20);
        check("post_reset_no_tx", sent.size(), 0);

        check("no_consecutive_start", consec_err, 0);
        check("no_start_while_uart_busy", overlap_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
